// File: rtl/regfile_scoreboard.sv
// Register file with busy-bit scoreboard and same-cycle write-back bypass.
// Decode reads two operands combinationally and asks whether an instruction may
// issue; R0 is hard-wired to zero and never tracked.
module regfile_scoreboard #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_dst,
  input  logic             iss_uses_b,
  output logic             stall,
  output logic [NREG-1:0]  busy_vec
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [NREG-1:0]  wr_hot;
  logic [NREG-1:0]  iss_hot;
  logic [NREG-1:0]  ebusy;
  logic             wr_live;
  logic             iss_ok;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign busy_vec = busy;

  // Decode write-back and issue one-hots, effective busy, stall and next busy.
  always_comb begin
    wr_hot   = '0;
    iss_hot  = '0;
    ebusy    = '0;
    stall    = 1'b0;
    iss_ok   = 1'b0;
    busy_nxt = busy;
    if (wr_live) wr_hot = NREG'(1) << wr_addr;
    if (iss_dst != '0) iss_hot = NREG'(1) << iss_dst;
    // A register retiring this cycle counts as ready; bit 0 never holds busy.
    ebusy    = busy & ~wr_hot;
    ebusy[0] = 1'b0;
    stall    = !clr && iss_en &&
               (ebusy[rd_addr_a] || (iss_uses_b && ebusy[rd_addr_b]) || ebusy[iss_dst]);
    iss_ok   = iss_en && !stall;
    // Issue is applied after the write-back clear so a same-register issue wins.
    busy_nxt = (busy & ~wr_hot) | (iss_ok ? iss_hot : '0);
    busy_nxt[0] = 1'b0;
  end

  // Operand read with write-back bypass; outputs held at zero during reset.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!clr) begin
      if (rd_addr_a != '0)
        rd_data_a = (wr_live && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
      if (rd_addr_b != '0)
        rd_data_b = (wr_live && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
    end
  end

  // Register rows: load-enabled storage, cleared asynchronously; R0 is never loaded.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard bits: cleared by write-back, set by an accepted issue.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: table-driven vectors with a
// queue of expected results, plus a hand-written asynchronous reset sequence.
module tb_regfile_scoreboard;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;
  logic             iss_en;
  logic [AW-1:0]    iss_dst;
  logic             iss_uses_b;
  logic             stall;
  logic [NREG-1:0]  busy_vec;

  regfile_scoreboard #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .iss_en(iss_en), .iss_dst(iss_dst), .iss_uses_b(iss_uses_b),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic             iss_en;
    logic [AW-1:0]    iss_dst;
    logic             uses_b;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             exp_stall;
    logic [NREG-1:0]  exp_busy;
  } vec_t;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             st;
    logic [NREG-1:0]  busy;
  } exp_t;

  localparam int NV = 21;
  vec_t tbl [NV];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    iss_en = 0; iss_dst = '0; iss_uses_b = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // wr_en addr data, ra rb, iss dst usesb, exp_a exp_b stall busy_after
    tbl[0]  = '{1, 3'd3, 16'h1234, 3'd3, 3'd0, 0, 3'd0, 0, 16'h1234, 16'h0000, 0, 8'h00}; // bypass R3
    tbl[1]  = '{1, 3'd0, 16'hFFFF, 3'd3, 3'd0, 0, 3'd0, 0, 16'h1234, 16'h0000, 0, 8'h00}; // R0 write ignored
    tbl[2]  = '{0, 3'd0, 16'h0000, 3'd0, 3'd3, 0, 3'd0, 0, 16'h0000, 16'h1234, 0, 8'h00};
    tbl[3]  = '{1, 3'd5, 16'h1111, 3'd5, 3'd0, 0, 3'd0, 0, 16'h1111, 16'h0000, 0, 8'h00};
    tbl[4]  = '{1, 3'd5, 16'hBEEF, 3'd5, 3'd3, 0, 3'd0, 0, 16'hBEEF, 16'h1234, 0, 8'h00}; // bypass over old
    tbl[5]  = '{0, 3'd0, 16'h0000, 3'd5, 3'd0, 0, 3'd0, 0, 16'hBEEF, 16'h0000, 0, 8'h00};
    tbl[6]  = '{0, 3'd0, 16'h0000, 3'd3, 3'd5, 1, 3'd2, 1, 16'h1234, 16'hBEEF, 0, 8'h04}; // issue R2
    tbl[7]  = '{0, 3'd0, 16'h0000, 3'd2, 3'd0, 1, 3'd7, 0, 16'h0000, 16'h0000, 1, 8'h04}; // RAW stall
    tbl[8]  = '{1, 3'd2, 16'h00AA, 3'd2, 3'd0, 1, 3'd7, 0, 16'h00AA, 16'h0000, 0, 8'h80}; // wb releases
    tbl[9]  = '{0, 3'd0, 16'h0000, 3'd1, 3'd0, 1, 3'd7, 0, 16'h0000, 16'h0000, 1, 8'h80}; // WAW stall
    tbl[10] = '{1, 3'd7, 16'h7777, 3'd7, 3'd0, 1, 3'd4, 0, 16'h7777, 16'h0000, 0, 8'h10};
    tbl[11] = '{0, 3'd0, 16'h0000, 3'd0, 3'd0, 1, 3'd4, 0, 16'h0000, 16'h0000, 1, 8'h10}; // WAW R4
    tbl[12] = '{0, 3'd0, 16'h0000, 3'd0, 3'd4, 1, 3'd1, 0, 16'h0000, 16'h0000, 0, 8'h12}; // B unused
    tbl[13] = '{0, 3'd0, 16'h0000, 3'd0, 3'd4, 1, 3'd3, 1, 16'h0000, 16'h0000, 1, 8'h12}; // B used
    tbl[14] = '{0, 3'd0, 16'h0000, 3'd0, 3'd0, 1, 3'd0, 1, 16'h0000, 16'h0000, 0, 8'h12}; // dst R0
    tbl[15] = '{0, 3'd0, 16'h0000, 3'd4, 3'd1, 0, 3'd4, 1, 16'h0000, 16'h0000, 0, 8'h12}; // no iss_en
    tbl[16] = '{0, 3'd0, 16'h0000, 3'd0, 3'd0, 1, 3'd6, 0, 16'h0000, 16'h0000, 0, 8'h52}; // issue R6
    tbl[17] = '{1, 3'd6, 16'h0042, 3'd6, 3'd0, 1, 3'd6, 0, 16'h0042, 16'h0000, 0, 8'h52}; // wb+reissue
    tbl[18] = '{0, 3'd0, 16'h0000, 3'd6, 3'd1, 0, 3'd0, 0, 16'h0042, 16'h0000, 0, 8'h52};
    tbl[19] = '{1, 3'd4, 16'h4444, 3'd4, 3'd0, 0, 3'd0, 0, 16'h4444, 16'h0000, 0, 8'h42};
    tbl[20] = '{1, 3'd3, 16'h5555, 3'd3, 3'd7, 0, 3'd0, 0, 16'h5555, 16'h7777, 0, 8'h42}; // non-busy wb

    idle();
    clr = 1;
    #12;
    chk("rst_busy", 0, 32'(busy_vec), 32'h0);
    chk("rst_stall", 0, 32'(stall), 32'h0);
    @(negedge clk);
    clr = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      iss_en = tbl[i].iss_en; iss_dst = tbl[i].iss_dst; iss_uses_b = tbl[i].uses_b;
      sb_q.push_back('{i, tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_stall, tbl[i].exp_busy});
      #1;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty[%0d] got 0 want 1", i);
      end else begin
        e = sb_q.pop_front();
        chk("rd_a", e.idx, 32'(rd_data_a), 32'(e.a));
        chk("rd_b", e.idx, 32'(rd_data_b), 32'(e.b));
        chk("stall", e.idx, 32'(stall), 32'(e.st));
        @(posedge clk);
        #1;
        chk("busy", e.idx, 32'(busy_vec), 32'(e.busy));
      end
    end

    // Asynchronous reset between edges with R3/R6 loaded and busy_vec=0x42.
    @(negedge clk);
    idle();
    rd_addr_a = 3'd6; rd_addr_b = 3'd3;
    wr_en = 1; wr_addr = 3'd6; wr_data = 16'hABCD;
    iss_en = 1; iss_dst = 3'd1; iss_uses_b = 1;
    #1;
    clr = 1;
    #1;
    chk("clr_rd_a", 100, 32'(rd_data_a), 32'h0);
    chk("clr_rd_b", 100, 32'(rd_data_b), 32'h0);
    chk("clr_busy", 100, 32'(busy_vec), 32'h0);
    chk("clr_stall", 100, 32'(stall), 32'h0);
    #1;
    clr = 0;
    wr_en = 0; iss_en = 0;
    #1;
    chk("post_rd_a", 101, 32'(rd_data_a), 32'h0);
    chk("post_rd_b", 101, 32'(rd_data_b), 32'h0);
    chk("post_busy", 101, 32'(busy_vec), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register bank for the 3-stage pipeline: NREG general registers of WIDTH bits.
- Each register row uses the load-enabled, clear-able per-bit storage behaviour.
- Downstream of the per-bit register slices; it is the consumer that assembles them into an addressable file.
- Adds a busy-bit scoreboard and write-back bypass so decode can detect RAW/WAW hazards and stall issue.

Parameters:
- WIDTH, 16, data width of each register.
- NREG, 8, number of registers, power of two, minimum 2.
- AW, 3, address width; must equal log2(NREG).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- wr_en  input  1  write-back strobe from the last pipe stage.
- wr_addr  input  AW  write-back destination register.
- wr_data  input  WIDTH  write-back data.
- rd_addr_a  input  AW  source A address, decode stage.
- rd_addr_b  input  AW  source B address, decode stage.
- rd_data_a  output  WIDTH  source A data, combinational.
- rd_data_b  output  WIDTH  source B data, combinational.
- iss_en  input  1  decode requests issue of an instruction that writes iss_dst.
- iss_dst  input  AW  destination of the issuing instruction.
- iss_uses_b  input  1  issuing instruction reads source B; A is always read.
- stall  output  1  issue blocked this cycle, combinational.
- busy_vec  output  NREG  registered scoreboard bits, for debug and verification.

Behaviour:
- Reset: clr=1 asynchronously forces every register to 0 and every busy bit to 0, so busy_vec=0.
  - While clr=1, stall=0 and rd_data_* = 0.
  - Reset mid-operation discards all pending writes and busy marks.
- R0:
  - Reads always return 0.
  - Writes to R0 are ignored.
  - R0 is never marked busy, and iss_dst=0 never causes a stall.
- Write:
  - On the rising clk edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
  - In the same edge, busy[wr_addr] ← 0 unless overridden by issue (see below).
- Read:
  - Combinational.
  - If wr_en=1, rd_addr_x=wr_addr and the address is ≠0, rd_data_x = wr_data (same-cycle bypass).
  - Otherwise rd_data_x = reg[rd_addr_x].
  - Read latency is 0 cycles; a write is visible to a read in the same cycle.
- Effective busy:
  - ebusy[r] = busy[r] AND NOT (wr_en AND wr_addr==r).
  - A register being written back this cycle is treated as ready.
- Stall, asserted only when iss_en=1:
  - stall = iss_en AND ( ebusy[rd_addr_a] OR (iss_uses_b AND ebusy[rd_addr_b]) OR ebusy[iss_dst] ).
  - The last term is the WAW check.
  - Address 0 terms are always 0.
- Issue:
  - On the rising edge with iss_en=1, stall=0 and iss_dst≠0, busy[iss_dst] ← 1.
  - A stalled issue has no effect; decode holds and retries.
- Simultaneous events:
  - Write-back and accepted issue to the same register in one cycle: the data write happens and busy ends at 1 (issue wins).
  - Write-back to a non-busy register updates data only; busy remains 0.
- Two different registers may be written back and issued in the same cycle independently.
- No other state. The block adds no pipeline latency; all decisions are within one cycle.

Test Plan:
- Reset: pulse clr asynchronously between edges with regs preloaded → all rd_data=0 and busy_vec=0 immediately, before the next edge.
- Write/read and R0: write R3←0x1234 then R0←0xFFFF → rd_addr_a=3 reads 0x1234, rd_addr_b=0 reads 0x0000; busy_vec unchanged.
- Bypass: in one cycle wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr_a=5 → rd_data_a=0xBEEF in that cycle while reg[5] still holds the old value.
- RAW stall:
  - Issue dst=2 (accepted, busy_vec=0x04).
  - Next cycle iss_en=1 with rd_addr_a=2 → stall=1 and no change.
  - In the cycle wr_en=1, wr_addr=2 arrives → stall=0, that issue is accepted, busy[2] cleared.
- WAW and operand B gating:
  - With busy_vec=0x10, an issue with iss_dst=4 → stall=1.
  - An issue with rd_addr_b=4 and iss_uses_b=0 → stall=0.
  - The same issue with iss_uses_b=1 → stall=1.
- Simultaneous write-back and re-issue: busy[6]=1; one cycle with wr_en wr_addr=6, wr_data=0x0042 and iss_en iss_dst=6 → stall=0, reg[6]=0x0042, busy_vec bit 6 stays 1.
